ir_mp_addsub_seq: RTL and testbench

Multi-precision add/subtract sequencer. It shares one N-bit add-with-carry / subtract-with-borrow word unit across the WORDS words of a wide operand and chains the carry or borrow from word 0 (least significant) upward, one word per cycle. It sits between a requester issuing wide arithmetic operations and a consumer of results, using valid/ready handshakes on both sides.

---
 rtl/ir_arith_pkg.sv | 31 +++
 rtl/ir_addsub_word.sv | 28 ++
 rtl/ir_mp_addsub_seq.sv | 123 ++++++++++++
 tb/tb_ir_mp_addsub_seq.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_arith_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer:
// operation encodings, FSM state type and the word-counter width helper.
package ir_arith_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_ADC = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_SBC = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Word counter needs at least one bit even for a single-word operand.
  function automatic int cnt_width(input int words);
    int w;
    w = $clog2(words);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic logic op_is_sub(input logic [1:0] op);
    return (op == OP_SUB) || (op == OP_SBC);
  endfunction

  function automatic logic op_uses_cin(input logic [1:0] op);
    return (op == OP_ADC) || (op == OP_SBC);
  endfunction

endpackage

// File: rtl/ir_addsub_word.sv
// Combinational N-bit add-with-carry / subtract-with-borrow word unit.
// In SUB mode COUT is the borrow-out (bit N of the (N+1)-bit difference).
module ir_addsub_word #(
  parameter int N = 8
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         CIN,
  input  logic         SUB,
  output logic [N-1:0] C,
  output logic         COUT
);

  logic [N:0] res;

  always_comb begin
    res = '0;
    if (SUB) begin
      res = {1'b0, A} - {1'b0, B} - {{N{1'b0}}, CIN};
    end else begin
      res = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, CIN};
    end
  end

  assign C    = res[N-1:0];
  assign COUT = res[N];

endmodule

// File: rtl/ir_mp_addsub_seq.sv
// Multi-precision add/subtract sequencer: one shared word unit walks the
// WORDS words of the operands from least significant upward, one per cycle.
module ir_mp_addsub_seq
  import ir_arith_pkg::*;
#(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [1:0]           OP,
  input  logic                 CIN,
  input  logic [N*WORDS-1:0]   A,
  input  logic [N*WORDS-1:0]   B,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [N*WORDS-1:0]   C,
  output logic                 COUT,
  output logic [1:0]           STATE_DBG
);

  localparam int W  = N * WORDS;
  localparam int KW = cnt_width(WORDS);
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; valid never waits on ready, and IN_VALID outside IDLE is dropped.
  state_e          state_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            sub_q;
  logic            cy_q;
  logic [KW-1:0]   k_q;
  logic [W-1:0]    c_q;
  logic            cout_q;

  logic [N-1:0]    a_word;
  logic [N-1:0]    b_word;
  logic [N-1:0]    w_c;
  logic            w_cout;

  always_comb begin
    a_word = '0;
    b_word = '0;
    a_word = a_q[int'(k_q)*N +: N];
    b_word = b_q[int'(k_q)*N +: N];
  end

  ir_addsub_word #(
    .N(N)
  ) u_word (
    .A    (a_word),
    .B    (b_word),
    .CIN  (cy_q),
    .SUB  (sub_q),
    .C    (w_c),
    .COUT (w_cout)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      cy_q        <= 1'b0;
      k_q         <= '0;
      c_q         <= '0;
      cout_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (IN_VALID) begin
            a_q        <= A;
            b_q        <= B;
            sub_q      <= op_is_sub(OP);
            cy_q       <= op_uses_cin(OP) ? CIN : 1'b0;
            k_q        <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          c_q[int'(k_q)*N +: N] <= w_c;
          cy_q                  <= w_cout;
          if (k_q == K_LAST) begin
            cout_q      <= w_cout;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        DONE: begin
          // Result is held until the consumer takes it.
          if (OUT_READY) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign IN_READY  = in_ready_q;
  assign OUT_VALID = out_valid_q;
  assign C         = c_q;
  assign COUT      = cout_q;
  assign STATE_DBG = state_q;

endmodule

// File: tb/tb_ir_mp_addsub_seq.sv
// Bench for ir_mp_addsub_seq: directed vectors and corner sequences on an
// N=8/WORDS=4 instance, then randomized traffic on four size configurations.
module tb_ir_mp_addsub_seq;
  import ir_arith_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Instance 0: N=8 WORDS=4, 1: N=8 WORDS=1, 2: N=3 WORDS=4, 3: N=3 WORDS=1
  logic        iv[4];
  logic        ordy[4];
  logic        cin_v[4];
  logic [1:0]  op_v[4];
  logic [31:0] a_v[4];
  logic [31:0] b_v[4];

  logic ir0, ir1, ir2, ir3;
  logic ov0, ov1, ov2, ov3;
  logic co0, co1, co2, co3;
  logic [1:0] st0, st1, st2, st3;
  logic [31:0] c0;
  logic [7:0]  c1;
  logic [11:0] c2;
  logic [2:0]  c3;

  ir_mp_addsub_seq #(.N(8), .WORDS(4)) u_dut0 (
    .CLK(clk), .RESET(rst), .IN_VALID(iv[0]), .IN_READY(ir0), .OP(op_v[0]),
    .CIN(cin_v[0]), .A(a_v[0]), .B(b_v[0]), .OUT_VALID(ov0), .OUT_READY(ordy[0]),
    .C(c0), .COUT(co0), .STATE_DBG(st0));

  ir_mp_addsub_seq #(.N(8), .WORDS(1)) u_dut1 (
    .CLK(clk), .RESET(rst), .IN_VALID(iv[1]), .IN_READY(ir1), .OP(op_v[1]),
    .CIN(cin_v[1]), .A(a_v[1][7:0]), .B(b_v[1][7:0]), .OUT_VALID(ov1),
    .OUT_READY(ordy[1]), .C(c1), .COUT(co1), .STATE_DBG(st1));

  ir_mp_addsub_seq #(.N(3), .WORDS(4)) u_dut2 (
    .CLK(clk), .RESET(rst), .IN_VALID(iv[2]), .IN_READY(ir2), .OP(op_v[2]),
    .CIN(cin_v[2]), .A(a_v[2][11:0]), .B(b_v[2][11:0]), .OUT_VALID(ov2),
    .OUT_READY(ordy[2]), .C(c2), .COUT(co2), .STATE_DBG(st2));

  ir_mp_addsub_seq #(.N(3), .WORDS(1)) u_dut3 (
    .CLK(clk), .RESET(rst), .IN_VALID(iv[3]), .IN_READY(ir3), .OP(op_v[3]),
    .CIN(cin_v[3]), .A(a_v[3][2:0]), .B(b_v[3][2:0]), .OUT_VALID(ov3),
    .OUT_READY(ordy[3]), .C(c3), .COUT(co3), .STATE_DBG(st3));

  // ---------------- accessors ----------------
  function automatic int cfg_n(input int idx);
    return (idx < 2) ? 8 : 3;
  endfunction

  function automatic int cfg_words(input int idx);
    return (idx % 2 == 0) ? 4 : 1;
  endfunction

  function automatic logic get_ir(input int idx);
    case (idx)
      0: return ir0;
      1: return ir1;
      2: return ir2;
      default: return ir3;
    endcase
  endfunction

  function automatic logic get_ov(input int idx);
    case (idx)
      0: return ov0;
      1: return ov1;
      2: return ov2;
      default: return ov3;
    endcase
  endfunction

  function automatic logic get_co(input int idx);
    case (idx)
      0: return co0;
      1: return co1;
      2: return co2;
      default: return co3;
    endcase
  endfunction

  function automatic logic [31:0] get_c(input int idx);
    case (idx)
      0: return c0;
      1: return {24'd0, c1};
      2: return {20'd0, c2};
      default: return {29'd0, c3};
    endcase
  endfunction

  // ---------------- reference model ----------------
  // Whole-operand arithmetic on wide integers; returns {cout, c}.
  function automatic logic [32:0] ref_model(input int w, input logic [1:0] op,
                                            input logic cin, input logic [31:0] a,
                                            input logic [31:0] b);
    longint unsigned ua, ub, ci, mask, s;
    logic co;
    ua   = a;
    ub   = b;
    ci   = ((op == OP_ADC) || (op == OP_SBC)) ? longint'(cin) : 0;
    mask = (64'd1 << w) - 1;
    if (op == OP_ADD || op == OP_ADC) begin
      s  = ua + ub + ci;
      co = ((s >> w) & 1) != 0;
    end else begin
      s  = ua - ub - ci;
      co = ua < (ub + ci);
    end
    return {co, 32'(s & mask)};
  endfunction

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [32:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input int idx, input logic v, input logic [1:0] op,
                        input logic cin, input logic [31:0] a, input logic [31:0] b);
    iv[idx]    = v;
    op_v[idx]  = op;
    cin_v[idx] = cin;
    a_v[idx]   = a;
    b_v[idx]   = b;
  endtask

  // Issue one op, measure edges from accept to OUT_VALID, then take the result.
  task automatic run_op(input int idx, input logic [1:0] op, input logic cin,
                        input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] c, output logic co, output int lat);
    int guard;
    set_in(idx, 1'b1, op, cin, a, b);
    guard = 0;
    while (!get_ir(idx) && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    iv[idx] = 1'b0;
    lat = 0;
    while (!get_ov(idx) && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    c  = get_c(idx);
    co = get_co(idx);
    ordy[idx] = 1'b1;
    @(posedge clk); #1;
    ordy[idx] = 1'b0;
  endtask

  function automatic logic [31:0] rand_operand(input logic [31:0] mask);
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return mask;
      default: return $urandom & mask;
    endcase
  endfunction

  task automatic run_random(input int idx, input int n_ops);
    int w, accepted, done, cycles;
    logic [31:0] mask;
    logic [32:0] e;
    w = cfg_n(idx) * cfg_words(idx);
    mask = 32'((64'd1 << w) - 1);
    exp_q.delete();
    accepted = 0;
    done = 0;
    cycles = 0;
    while (done < n_ops && cycles < 20000) begin
      if (accepted < n_ops)
        set_in(idx, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), rand_operand(mask), rand_operand(mask));
      else
        iv[idx] = 1'b0;
      ordy[idx] = $urandom_range(0, 3) != 0;
      if (iv[idx] && get_ir(idx)) begin
        exp_q.push_back(ref_model(w, op_v[idx], cin_v[idx], a_v[idx], b_v[idx]));
        accepted++;
      end
      if (get_ov(idx) && ordy[idx]) begin
        if (exp_q.size() == 0) begin
          check($sformatf("rand%0d_unexpected_result", idx), 1, 0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("rand%0d_op%0d", idx, done), {get_co(idx), get_c(idx)}, e);
        end
        done++;
      end
      @(posedge clk); #1;
      cycles++;
    end
    if (done < n_ops) check($sformatf("rand%0d_timeout_done", idx), done, n_ops);
    iv[idx]   = 1'b0;
    ordy[idx] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    string       name;
    logic [1:0]  op;
    logic        cin;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        co;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] c_got, c_hold;
    logic co_got, co_hold;
    int lat;
    bit seen;

    vecs[0] = '{"add_ff_1",      OP_ADD, 1'b0, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0};
    vecs[1] = '{"add_wrap",      OP_ADD, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
    vecs[2] = '{"adc_wrap",      OP_ADC, 1'b1, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1};
    vecs[3] = '{"add_cin_ign",   OP_ADD, 1'b1, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0};
    vecs[4] = '{"sub_0_1",       OP_SUB, 1'b0, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1};
    vecs[5] = '{"sbc_100_0",     OP_SBC, 1'b1, 32'h00000100, 32'h00000000, 32'h000000FF, 1'b0};
    vecs[6] = '{"sbc_eq_bin",    OP_SBC, 1'b1, 32'h12345678, 32'h12345678, 32'hFFFFFFFF, 1'b1};
    vecs[7] = '{"adc_7f",        OP_ADC, 1'b1, 32'h7F7F7F7F, 32'h01010101, 32'h80808081, 1'b0};
    vecs[8] = '{"sub_msb",       OP_SUB, 1'b0, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0};
    vecs[9] = '{"sub_cin_ign",   OP_SUB, 1'b1, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0};

    for (int i = 0; i < 4; i++) begin
      set_in(i, 1'b0, OP_ADD, 1'b0, 32'd0, 32'd0);
      ordy[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_in_ready", ir0, 1);
    check("rst_out_valid", ov0, 0);
    check("rst_c", c0, 0);
    check("rst_cout", co0, 0);
    check("rst_state", st0, IDLE);

    // Table-driven vectors with latency check
    for (int i = 0; i < 10; i++) begin
      run_op(0, vecs[i].op, vecs[i].cin, vecs[i].a, vecs[i].b, c_got, co_got, lat);
      check({vecs[i].name, "_c"}, c_got, vecs[i].c);
      check({vecs[i].name, "_cout"}, co_got, vecs[i].co);
      check({vecs[i].name, "_latency"}, lat, 4);
    end

    // Backpressure in DONE: result held, requests ignored
    set_in(0, 1'b1, OP_ADD, 1'b0, 32'h11111111, 32'h22222222);
    @(posedge clk); #1;
    iv[0] = 1'b0;
    lat = 0;
    while (!ov0 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    c_hold = c0;
    co_hold = co0;
    check("bp_c", c_hold, 32'h33333333);
    check("bp_cout", co_hold, 0);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", ov0, 1);
      check("bp_in_ready", ir0, 0);
      check("bp_c_stable", c0, c_hold);
      check("bp_cout_stable", co0, co_hold);
      if (i == 2) set_in(0, 1'b1, OP_SUB, 1'b0, 32'h5, 32'h1);
      else iv[0] = 1'b0;
      @(posedge clk); #1;
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b0;
    check("bp_release_out_valid", ov0, 0);
    check("bp_release_in_ready", ir0, 1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (ov0) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("bp_no_extra_result", seen, 0);

    // Reset after two words of RUN
    set_in(0, 1'b1, OP_ADD, 1'b0, 32'h01010101, 32'h01010101);
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check("midrun_state", st0, RUN);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", ir0, 1);
    check("midrst_out_valid", ov0, 0);
    check("midrst_c", c0, 0);
    check("midrst_cout", co0, 0);
    check("midrst_state", st0, IDLE);
    run_op(0, OP_ADD, 1'b0, 32'd1, 32'd1, c_got, co_got, lat);
    check("after_rst_add_c", c_got, 2);
    check("after_rst_add_cout", co_got, 0);

    // Reset and request on the same edge: reset wins
    rst = 1'b1;
    set_in(0, 1'b1, OP_ADD, 1'b0, 32'd7, 32'd7);
    @(posedge clk); #1;
    rst = 1'b0;
    iv[0] = 1'b0;
    check("rst_vs_req_state", st0, IDLE);
    check("rst_vs_req_in_ready", ir0, 1);
    seen = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (ov0) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("rst_vs_req_no_result", seen, 0);

    // Randomized traffic on all four configurations
    for (int i = 0; i < 4; i++) run_random(i, 300);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
